// File: rtl/alu_seq_if.sv
// Handshake and result bus between the register-read stage, alu_seq and writeback.
// master = upstream/downstream side; slave = alu_seq.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       operation;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, a, b, operation, out_ready,
    input  in_ready, out_valid, result, result_hi, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, operation, out_ready,
    output in_ready, out_valid, result, result_hi, zero, ovf
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith/compare, iterative shift-add multiply and,
// when ALU_SEQ_DIV_EN is defined, iterative restoring divide.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_SLTU = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, out_valid_q;

  // Two's-complement overflow: like-signed operands giving an opposite-signed result.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  logic signed [WIDTH-1:0] a_s, b_s;
  logic        [WIDTH-1:0] add_w, sub_w;
  logic        [WIDTH:0]   mul_sum;

  assign a_s   = bus.a;
  assign b_s   = bus.b;
  assign add_w = bus.a + bus.b;
  assign sub_w = bus.a - bus.b;

  // hi_q accumulates the upper product while res_q shifts the multiplier out LSB-first.
  assign mul_sum = {1'b0, hi_q} + (res_q[0] ? {1'b0, opnd_q} : '0);

`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;

  // Partial remainder in hi_q, dividend shifts out of res_q MSB-first as quotient shifts in.
  assign rem_sh   = {hi_q, res_q[WIDTH-1]};
  assign div_ge   = rem_sh >= {1'b0, opnd_q};
  assign div_diff = rem_sh[WIDTH-1:0] - opnd_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    hi_d    = hi_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_d = S_DONE;
          cnt_d   = '0;
          hi_d    = '0;
          ovf_d   = 1'b0;
          case (bus.operation)
            OP_AND:  res_d = bus.a & bus.b;
            OP_OR:   res_d = bus.a | bus.b;
            OP_ADD: begin
              res_d = add_w;
              ovf_d = add_ovf(bus.a[WIDTH-1], bus.b[WIDTH-1], add_w[WIDTH-1]);
            end
            OP_SUB: begin
              res_d = sub_w;
              ovf_d = add_ovf(bus.a[WIDTH-1], ~bus.b[WIDTH-1], sub_w[WIDTH-1]);
            end
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_MUL: begin
              state_d = S_MUL;
              opnd_d  = bus.a;
              res_d   = bus.b;
            end
            OP_DIV: begin
`ifdef ALU_SEQ_DIV_EN
              if (bus.b == '0) begin
                res_d = '1;
                hi_d  = bus.a;
                ovf_d = 1'b1;
              end else begin
                state_d = S_DIV;
                opnd_d  = bus.b;
                res_d   = bus.a;
              end
`else
              res_d = '0;
              ovf_d = 1'b1;
`endif
            end
            default: res_d = '0;
          endcase
        end
      end
      S_MUL: begin
        hi_d  = mul_sum[WIDTH:1];
        res_d = {mul_sum[0], res_q[WIDTH-1:1]};
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef ALU_SEQ_DIV_EN
      S_DIV: begin
        hi_d  = div_ge ? div_diff : rem_sh[WIDTH-1:0];
        res_d = {res_q[WIDTH-2:0], div_ge};
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // zero is only refreshed as a result lands, so it stays tied to the held result.
    if (state_d == S_DONE && state_q != S_DONE) zero_d = (res_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      opnd_q      <= '0;
      res_q       <= '0;
      hi_q        <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      opnd_q      <= opnd_d;
      res_q       <= res_d;
      hi_q        <= hi_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_DONE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = res_q;
  assign bus.result_hi = hi_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU for the lab datapath. It is the next generation of the combinational 3-bit-opcode ALU: it keeps that ALU's opcode encodings and adds SLTU, an iterative multiply and an optional iterative divide. Operands are taken in and results handed out through valid/ready handshakes. It sits between the register-read stage and writeback, and it stalls issue while a multiply or divide is in flight.

## Interface
Parameters:
- WIDTH, 32: operand and result width in bits; legal values are 4 to 64.

Ports:
- clk  input  1  clock; everything is sampled on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  the upstream stage presents an operation.
- in_ready  output  1  the block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- operation  input  3  opcode: 000 AND, 001 OR, 010 ADD, 011 MUL, 100 DIV, 101 SLTU, 110 SUB, 111 SLT.
- out_valid  output  1  result registers hold a valid result.
- out_ready  input  1  downstream accepts the result.
- result  output  WIDTH  primary result (low product or quotient for MUL/DIV).
- result_hi  output  WIDTH  high product (MUL) or remainder (DIV); 0 for all other ops.
- zero  output  1  1 when result equals 0.
- ovf  output  1  signed overflow on ADD/SUB, divide-by-zero, or illegal op.

## Operation
- State machine with states IDLE, MUL, DIV, DONE. Reset enters IDLE.
- in_ready = (state == IDLE). An operation is accepted when in_valid && in_ready. a, b and operation are captured at acceptance; later changes to them are ignored.
- Single-cycle ops (AND, OR, ADD, SUB, SLT, SLTU):
  - The result is computed and registered on the acceptance edge.
  - The state goes IDLE -> DONE.
- SLT is a signed compare; SLTU is unsigned. Both produce result = {WIDTH-1 zeros, cmp}.
- ADD/SUB wrap modulo 2^WIDTH.
  - ovf = 1 on signed overflow: the operands' sign bits, with B's sign inverted for SUB, are equal and the result's sign differs from them.
- MUL: unsigned shift-add with one partial-product bit per cycle.
  - Takes WIDTH iterations in state MUL, then goes to DONE.
  - {result_hi, result} = a*b, a full 2*WIDTH-bit product. ovf = 0.
- DIV: unsigned restoring division with one quotient bit per cycle.
  - Takes WIDTH iterations in state DIV, then goes to DONE.
  - result = a/b, result_hi = a%b.
  - If b == 0 the block skips the iterations and goes straight to DONE with result = all ones, result_hi = a, ovf = 1.
- An iteration counter of width clog2(WIDTH)+1 counts from 0 to WIDTH-1. The last iteration writes the final value and moves to DONE.
- DONE: out_valid = 1.
  - result, result_hi, zero and ovf hold stable until out_ready is sampled high.
  - When out_ready is sampled high, the state goes to IDLE and out_valid drops on that edge.
- zero is registered together with result and is 1 exactly when result == 0. It is valid whenever out_valid = 1.

## Timing
- Reset values: in_ready = 1 (IDLE), out_valid = 0, result = 0, result_hi = 0, zero = 0, ovf = 0. Internal counter and operand registers are also 0.
- When rst_n is asserted the block goes to IDLE immediately, asynchronously, from any state. An in-flight MUL/DIV is discarded and no result is produced.
- Latency is counted from the acceptance edge to the first cycle with out_valid = 1:
  - 1 cycle for single-cycle ops and for divide-by-zero;
  - WIDTH+1 cycles for MUL and DIV.
- Best throughput is one operation every 2 cycles. in_ready is 0 for the whole of MUL, DIV and DONE.
- While out_valid = 1 and out_ready = 0, the block holds its outputs indefinitely. A stalled result is never overwritten.
- in_valid during a busy state is ignored and does not have to stay high. The upstream stage must hold it until in_ready is high.
- out_ready may be high before out_valid. In that case the result is consumed on the first DONE edge, so out_valid is high for exactly one cycle.

## Configuration
- Macro ALU_SEQ_DIV_EN.
- Defined: DIV (opcode 100) behaves as described above, and the divider datapath is compiled in.
- Undefined: no divider hardware is built. Opcode 100 is handled as a single-cycle illegal op: result = 0, result_hi = 0, zero = 1, ovf = 1, with out_valid asserted 1 cycle after acceptance.

## Test plan
- Reset: hold rst_n low, then release. Required: in_ready = 1, out_valid = 0, result = 0, zero = 0.
- Single-cycle ops at WIDTH=32:
  - ADD 0x7FFFFFFF + 1 -> result 0x80000000, ovf 1, out_valid on the next cycle.
  - SUB 5 - 5 -> result 0, zero 1, ovf 0.
  - SLT 0xFFFFFFFF vs 1 -> result 1; SLTU with the same operands -> result 0.
- MUL 0xFFFFFFFF * 0xFFFFFFFF -> result_hi 0xFFFFFFFE, result 0x00000001, out_valid exactly 33 cycles after acceptance. in_ready is 0 throughout and a second in_valid pulse during this time is ignored.
- DIV with ALU_SEQ_DIV_EN defined:
  - 100/7 -> result 14, result_hi 2, latency 33 cycles.
  - 9/0 -> result 0xFFFFFFFF, result_hi 9, ovf 1, latency 1 cycle.
  - With the macro undefined, DIV -> result 0, ovf 1, latency 1 cycle.
- Backpressure: hold out_ready low for 10 cycles after an ADD. Outputs stay stable and in_ready stays 0. Raise out_ready: out_valid falls and in_ready rises on the same edge.
- Reset mid-MUL: assert rst_n low 10 cycles into a MUL. All outputs return to their reset values, no out_valid pulse appears, and the next ADD completes normally.
